// File: rtl/link_ring_node.sv
// link_ring_node: one stop on a unidirectional token ring.
//   Ring-in tokens addressed to ID are delivered locally (o_rx_*); all other
//   tokens are forwarded downstream one cycle later. Local words enter through
//   an injection FIFO and take the ring-out slot only when it is free.
//   Pass-through traffic always wins over injection.
// Ports:
//   i_clk, i_rstn                       clock, async active-low reset
//   i_wen, i_token, i_clk_cnt, i_id     ring-in token
//   i_inj_valid, i_inj_token, i_inj_dst local injection request
//   o_inj_ready                         injection FIFO not full
//   o_wen_down, o_token_down,
//   o_clk_cnt_down, o_id_down           registered ring-out token
//   o_rx_valid, o_rx_token, o_rx_clk_cnt registered local delivery
//   o_stall_cnt                         saturating blocked-injection cycles
module link_ring_node #(
    parameter int unsigned ID         = 0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_wen,
    input  logic [31:0] i_token,
    input  logic [31:0] i_clk_cnt,
    input  logic [31:0] i_id,
    input  logic        i_inj_valid,
    input  logic [31:0] i_inj_token,
    input  logic [31:0] i_inj_dst,
    output logic        o_inj_ready,
    output logic        o_wen_down,
    output logic [31:0] o_token_down,
    output logic [31:0] o_clk_cnt_down,
    output logic [31:0] o_id_down,
    output logic        o_rx_valid,
    output logic [31:0] o_rx_token,
    output logic [31:0] o_rx_clk_cnt,
    output logic [15:0] o_stall_cnt
);

    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam logic [31:0] NODE_ID = 32'(ID);

    // FIFO entry: {dst, token}
    logic [63:0]   mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]   cnt_q;

    logic          fifo_empty, fifo_full;
    logic          consume, forward, slot_free, push, pop;
    logic [63:0]   head;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign o_inj_ready = i_rstn & ~fifo_full;

    assign consume   = i_wen && (i_id == NODE_ID);
    assign forward   = i_wen && (i_id != NODE_ID);
    assign slot_free = ~forward;
    assign push      = i_inj_valid & o_inj_ready;
    assign pop       = slot_free & ~fifo_empty;
    assign head      = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Storage needs no reset: pointer reset alone discards the contents.
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {i_inj_dst, i_inj_token};
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_q          <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            o_wen_down     <= 1'b0;
            o_token_down   <= '0;
            o_clk_cnt_down <= '0;
            o_id_down      <= '0;
            o_rx_valid     <= 1'b0;
            o_rx_token     <= '0;
            o_rx_clk_cnt   <= '0;
            o_stall_cnt    <= '0;
        end else begin
            cnt_q      <= cnt_q + 32'd1;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            o_wen_down <= forward | pop;
            o_rx_valid <= consume;

            if (forward) begin
                o_token_down   <= i_token;
                o_clk_cnt_down <= i_clk_cnt;
                o_id_down      <= i_id;
            end else if (pop) begin
                o_token_down   <= head[31:0];
                o_id_down      <= head[63:32];
                o_clk_cnt_down <= cnt_q;
            end

            if (consume) begin
                o_rx_token   <= i_token;
                o_rx_clk_cnt <= i_clk_cnt;
            end

            if (forward && !fifo_empty && (o_stall_cnt != 16'hFFFF))
                o_stall_cnt <= o_stall_cnt + 16'd1;
        end
    end

endmodule

// File: doc/link_ring_node.md
LINK_RING_NODE -- requirements
Module: link_ring_node

Interface
REQ-001 SHALL have parameter ID, default 0: ring node identity; a token whose id equals ID is consumed here.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: local injection FIFO depth; power of two, minimum 2.
REQ-003 SHALL have port i_clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rstn, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port i_wen, input, 1: ring-in token valid from the upstream node.
REQ-006 SHALL have port i_token, input, 32: ring-in token payload.
REQ-007 SHALL have port i_clk_cnt, input, 32: ring-in origin timestamp.
REQ-008 SHALL have port i_id, input, 32: ring-in destination id.
REQ-009 SHALL have port i_inj_valid, input, 1: local injection request.
REQ-010 SHALL have port i_inj_token, input, 32: local injection payload.
REQ-011 SHALL have port i_inj_dst, input, 32: local injection destination id.
REQ-012 SHALL have port o_inj_ready, output, 1: injection FIFO can accept a word.
REQ-013 SHALL have port o_wen_down, output, 1: ring-out valid, feeding the downstream split link.
REQ-014 SHALL have port o_token_down, output, 32: ring-out payload.
REQ-015 SHALL have port o_clk_cnt_down, output, 32: ring-out timestamp.
REQ-016 SHALL have port o_id_down, output, 32: ring-out destination id.
REQ-017 SHALL have port o_rx_valid, output, 1: one-cycle pulse delivering a consumed token locally.
REQ-018 SHALL have port o_rx_token, output, 32: delivered payload.
REQ-019 SHALL have port o_rx_clk_cnt, output, 32: delivered origin timestamp.
REQ-020 SHALL have port o_stall_cnt, output, 16: saturating count of blocked-injection cycles.

Function
REQ-021 SHALL keep a free-running 32-bit cycle counter cnt: +1 every cycle after reset, wrapping 0xFFFFFFFF->0.
REQ-022 SHALL register all ring-out and rx outputs, giving exactly one cycle from i_wen to o_wen_down or o_rx_valid.
REQ-023 SHALL, when i_wen=1 and i_id==ID, assert o_rx_valid next cycle with o_rx_token=i_token and o_rx_clk_cnt=i_clk_cnt; that token is not forwarded.
REQ-024 SHALL, when i_wen=1 and i_id!=ID, forward next cycle with o_wen_down=1 and token, clk_cnt and id unchanged.
REQ-025 SHALL define the output slot as free when i_wen=0 or the incoming token was consumed (i_id==ID).
REQ-026 SHALL give pass-through traffic absolute priority over injection.
REQ-027 SHALL, when the slot is free and the FIFO is non-empty, pop the head and drive next cycle o_wen_down=1, o_token_down=head token, o_id_down=head dst, o_clk_cnt_down=cnt at pop.
REQ-028 SHALL allow consume and pop in the same cycle, with o_rx_valid and o_wen_down both asserted next cycle.
REQ-029 SHALL drive o_wen_down=0 next cycle when nothing is forwarded or popped; data outputs hold their last values.
REQ-030 SHALL set o_inj_ready = FIFO not full, and push when i_inj_valid and o_inj_ready are both 1.
REQ-031 SHALL NOT bypass: a word pushed into an empty FIFO is poppable the next cycle at the earliest, giving 2 cycles minimum inject-to-o_wen_down latency.
REQ-032 SHALL allow a simultaneous push and pop in any state except full; when full, no push occurs because ready=0.
REQ-033 SHALL inject a word with dst==ID onto the ring like any other word; it is consumed when it returns.
REQ-034 SHALL increment o_stall_cnt each cycle the FIFO is non-empty and the slot is occupied by forwarding, saturating at 0xFFFF.
REQ-035 SHALL handle FIFO pointers with (log2 FIFO_DEPTH)+1 bits and wrap-around; full and empty derive from the MSB compare.

Reset
REQ-036 SHALL, while i_rstn=0, asynchronously clear cnt, o_stall_cnt, all ring-out and rx outputs and the FIFO pointers, and drive o_inj_ready=0.
REQ-037 SHALL discard any in-flight tokens and FIFO contents when reset is asserted mid-operation; o_inj_ready rises in the first cycle after deassertion.

Verification
REQ-038 SHALL cover pass-through: ID=2, i_wen=1, i_id=5, i_token=0xA5A5, i_clk_cnt=7 -> next cycle o_wen_down=1, o_id_down=5, o_token_down=0xA5A5, o_clk_cnt_down=7, and o_rx_valid=0.
REQ-039 SHALL cover consume plus inject: ID=2, FIFO holds {0x11, dst 3}, i_wen=1, i_id=2, i_token=0xBEEF -> next cycle o_rx_valid=1 with o_rx_token=0xBEEF, and o_wen_down=1 with o_token_down=0x11, o_id_down=3, o_clk_cnt_down=cnt at pop.
REQ-040 SHALL cover backpressure: continuous foreign i_wen=1 with 5 pushes attempted at FIFO_DEPTH=4 -> o_inj_ready=0 after 4 pushes, o_stall_cnt increments every cycle, no injected word appears on ring-out.
REQ-041 SHALL cover saturation: the stall condition held for 70000 cycles -> o_stall_cnt=0xFFFF and stable.
REQ-042 SHALL cover empty-FIFO latency: idle ring, one push at cycle t -> o_wen_down=1 at t+2 only, then 0.
REQ-043 SHALL cover mid-operation reset: i_rstn low for 1 cycle with FIFO holding 3 words -> all outputs 0 immediately, no stale pops, o_inj_ready=1 on the first cycle after release.
